// File: rtl/spmv_row_engine.sv
// CSR sparse matrix x dense vector engine: walks 16 rows, streams nonzeros from
// external value/column SRAMs, accumulates in 32 bits and writes saturated results.
module spmv_row_engine #(
    parameter int N_ROWS = 16,
    parameter int DW     = 16,
    parameter int PW     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_start,
    input  logic [(N_ROWS+1)*PW-1:0]   i_row_ptr,
    input  logic [N_ROWS*DW-1:0]       i_in_vector,
    output logic                       o_nz_rd,
    output logic [PW-1:0]              o_nz_addr,
    input  logic signed [DW-1:0]       i_val_data,
    input  logic [3:0]                 i_col_data,
    output logic [N_ROWS*DW-1:0]       o_register,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [2:0]                 o_dbg_state
);

    // Handshake: i_start is a single-cycle request honoured only in IDLE. Each
    // o_nz_rd=1 cycle issues one SRAM read at o_nz_addr; its i_val_data and
    // i_col_data are consumed on the following rising edge, with no back-pressure.

    localparam int RW = $clog2(N_ROWS);
    localparam int AW = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ROW   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - AW'(1);

    logic [2:0]               state;
    logic [RW-1:0]            r;
    logic [PW-1:0]            k;
    logic [PW-1:0]            end_q;
    logic [PW-1:0]            addr_q;
    logic                     rd_q;
    logic signed [AW-1:0]     acc;
    logic signed [DW-1:0]     res [N_ROWS];

    logic [PW-1:0]            rp  [N_ROWS+1];
    logic signed [DW-1:0]     vec [N_ROWS];
    logic [RW:0]              r_next;
    logic signed [2*DW-1:0]   prod;
    logic signed [DW-1:0]     sat;

    genvar g;
    generate
        for (g = 0; g <= N_ROWS; g++) begin : g_rp
            assign rp[g] = i_row_ptr[g*PW +: PW];
        end
        for (g = 0; g < N_ROWS; g++) begin : g_vec
            assign vec[g]                = i_in_vector[g*DW +: DW];
            assign o_register[g*DW +: DW] = res[g];
        end
    endgenerate

    assign r_next = {1'b0, r} + (RW+1)'(1);
    assign prod   = i_val_data * vec[i_col_data];

    always_comb begin
        sat = acc[DW-1:0];
        if (acc > SAT_HI)
            sat = SAT_HI[DW-1:0];
        else if (acc < SAT_LO)
            sat = SAT_LO[DW-1:0];
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= S_IDLE;
            r      <= '0;
            k      <= '0;
            end_q  <= '0;
            addr_q <= '0;
            rd_q   <= 1'b0;
            acc    <= '0;
            for (int i = 0; i < N_ROWS; i++) res[i] <= '0;
        end else begin
            rd_q <= (state == S_FETCH);
            // Data returns one cycle after each issued read, so DRAIN picks up the last one.
            if (rd_q) acc <= acc + AW'(prod);
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state <= S_ROW;
                        r     <= '0;
                        acc   <= '0;
                        for (int i = 0; i < N_ROWS; i++) res[i] <= '0;
                    end
                end
                S_ROW: begin
                    k     <= rp[r];
                    end_q <= rp[r_next];
                    acc   <= '0;
                    // Non-monotonic pointers are treated as an empty row.
                    state <= (rp[r_next] <= rp[r]) ? S_WB : S_FETCH;
                end
                S_FETCH: begin
                    addr_q <= k;
                    k      <= k + PW'(1);
                    if (k + PW'(1) == end_q) state <= S_DRAIN;
                end
                S_DRAIN: state <= S_WB;
                S_WB: begin
                    res[r] <= sat;
                    r      <= r + RW'(1);
                    state  <= (r == RW'(N_ROWS - 1)) ? S_DONE : S_ROW;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_nz_rd     = (state == S_FETCH);
    assign o_nz_addr   = (state == S_FETCH) ? k : addr_q;
    assign o_busy      = (state == S_ROW) || (state == S_FETCH) ||
                         (state == S_DRAIN) || (state == S_WB);
    assign o_done      = (state == S_DONE);
    assign o_dbg_state = state;

endmodule
